// File: rtl/stb_host_reader.sv
// stb_host_reader: host-side sequencer for the stream trace buffer.
// On an accepted start it writes one control word, then consumes status words
// until the trigger bit is seen. It then drains NUM_WORDS trace words and emits
// each word LSB-byte-first on a byte ready/valid stream.
// Optional build macro STB_HOST_TIMEOUT_EN bounds the trigger wait to
// TIMEOUT_CYCLES cycles and reports an expiry on the sticky ERROR_O flag.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | waiting for START_I
// SEND_CTRL  | presenting the control word until it is accepted
// WAIT_TRIG  | accepting status words until the trigger bit is seen
// READ_WORD  | accepting the next trace word
// SHIFT_OUT  | emitting the captured word one byte at a time
// DONE       | one-cycle completion pulse, then back to IDLE

module stb_host_reader #(
  parameter int CONTROL_BITS   = 32,
  parameter int STATUS_BITS    = 16,
  parameter int TRG_BIT        = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    CLK_I,
  input  logic                    RST_NI,
  input  logic                    START_I,
  input  logic [CONTROL_BITS-1:0] CONFIG_I,
  output logic                    BUSY_O,
  output logic                    DONE_O,
  output logic                    ERROR_O,
  output logic                    CONTROL_VALID_O,
  input  logic                    CONTROL_READY_I,
  output logic [CONTROL_BITS-1:0] CONTROL_O,
  input  logic                    STATUS_VALID_I,
  output logic                    STATUS_READY_O,
  input  logic [STATUS_BITS-1:0]  STATUS_I,
  input  logic                    DATA_VALID_I,
  output logic                    DATA_READY_O,
  input  logic [DATA_WIDTH-1:0]   DATA_I,
  output logic                    BYTE_VALID_O,
  input  logic                    BYTE_READY_I,
  output logic [7:0]              BYTE_O
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int WCW    = $clog2(NUM_WORDS) + 1;
  localparam int BCW    = $clog2(NBYTES) + 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CTRL,
    S_WAIT_TRIG,
    S_READ_WORD,
    S_SHIFT_OUT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CONTROL_BITS-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ctrl_valid_q, ctrl_valid_d;
  logic                    status_ready_q, status_ready_d;
  logic                    data_ready_q, data_ready_d;
  logic                    byte_valid_q, byte_valid_d;
  logic [1:0]              rst_sync_q;
  logic                    rst_n_int;

`ifdef STB_HOST_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           error_q, error_d;
`else
  logic [31:0]    unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Only the trigger bit of the status word steers the sequencer.
  logic unused_status;
  assign unused_status = ^STATUS_I;

  // Reset asserts immediately and releases two clocks after RST_NI rises.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // Next-state, datapath and registered-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
`ifdef STB_HOST_TIMEOUT_EN
    tmo_d      = tmo_q;
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START_I) begin
          ctrl_d  = CONFIG_I;
          state_d = S_SEND_CTRL;
`ifdef STB_HOST_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      S_SEND_CTRL: begin
        if (ctrl_valid_q && CONTROL_READY_I) begin
          state_d = S_WAIT_TRIG;
`ifdef STB_HOST_TIMEOUT_EN
          tmo_d   = TCW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      S_WAIT_TRIG: begin
        if (status_ready_q && STATUS_VALID_I && STATUS_I[TRG_BIT]) begin
          word_cnt_d = '0;
          state_d    = S_READ_WORD;
        end
`ifdef STB_HOST_TIMEOUT_EN
        // Down-counter reaches terminal count on the last permitted cycle.
        else if (tmo_q == '0) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      S_READ_WORD: begin
        if (data_ready_q && DATA_VALID_I) begin
          shift_d    = DATA_I;
          byte_cnt_d = '0;
          state_d    = S_SHIFT_OUT;
        end
      end
      S_SHIFT_OUT: begin
        if (byte_valid_q && BYTE_READY_I) begin
          shift_d    = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            if (word_cnt_q == LAST_WORD) begin
              state_d = S_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              state_d    = S_READ_WORD;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the upcoming state.
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    ctrl_valid_d   = (state_d == S_SEND_CTRL);
    status_ready_d = (state_d == S_WAIT_TRIG);
    data_ready_d   = (state_d == S_READ_WORD);
    byte_valid_d   = (state_d == S_SHIFT_OUT);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK_I or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q        <= S_IDLE;
      ctrl_q         <= '0;
      shift_q        <= '0;
      word_cnt_q     <= '0;
      byte_cnt_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      ctrl_valid_q   <= 1'b0;
      status_ready_q <= 1'b0;
      data_ready_q   <= 1'b0;
      byte_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctrl_q         <= ctrl_d;
      shift_q        <= shift_d;
      word_cnt_q     <= word_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      ctrl_valid_q   <= ctrl_valid_d;
      status_ready_q <= status_ready_d;
      data_ready_q   <= data_ready_d;
      byte_valid_q   <= byte_valid_d;
    end
  end

`ifdef STB_HOST_TIMEOUT_EN
  // Trigger-wait timer and sticky timeout flag.
  always_ff @(posedge CLK_I or negedge rst_n_int) begin
    if (!rst_n_int) begin
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end
  assign ERROR_O = error_q;
`else
  assign ERROR_O = 1'b0;
`endif

  assign BUSY_O          = busy_q;
  assign DONE_O          = done_q;
  assign CONTROL_VALID_O = ctrl_valid_q;
  assign CONTROL_O       = ctrl_q;
  assign STATUS_READY_O  = status_ready_q;
  assign DATA_READY_O    = data_ready_q;
  assign BYTE_VALID_O    = byte_valid_q;
  assign BYTE_O          = shift_q[7:0];

endmodule

// File: tb/tb_stb_host_reader.sv
// Testbench for stb_host_reader (NUM_WORDS=2, DATA_WIDTH=32, TIMEOUT_CYCLES=100).
// Acts as the trace buffer and byte sink; expected bytes are derived from the
// trace words in LSB-first order. The timeout scenario runs only when
// STB_HOST_TIMEOUT_EN is defined.
module tb_stb_host_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg;
  logic        busy, done, err;
  logic        cvalid, crdy;
  logic [31:0] ctrl;
  logic        svalid, srdy;
  logic [15:0] stat;
  logic        dvalid, drdy;
  logic [31:0] din;
  logic        bvalid, brdy;
  logic [7:0]  bout;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] status_q[$];
  logic [31:0] data_q[$];
  logic [31:0] got_ctrl[$];
  logic [7:0]  got_bytes[$];
  logic [7:0]  exp_bytes[$];
  int          done_cnt;

  int ctrl_stall, byte_stall_at, byte_stall_len, abort_at;
  bit rnd_bp, poke_start;

  stb_host_reader #(
    .CONTROL_BITS(32), .STATUS_BITS(16), .TRG_BIT(0),
    .DATA_WIDTH(32), .NUM_WORDS(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK_I(clk), .RST_NI(rst_n), .START_I(start), .CONFIG_I(cfg),
    .BUSY_O(busy), .DONE_O(done), .ERROR_O(err),
    .CONTROL_VALID_O(cvalid), .CONTROL_READY_I(crdy), .CONTROL_O(ctrl),
    .STATUS_VALID_I(svalid), .STATUS_READY_O(srdy), .STATUS_I(stat),
    .DATA_VALID_I(dvalid), .DATA_READY_O(drdy), .DATA_I(din),
    .BYTE_VALID_O(bvalid), .BYTE_READY_I(brdy), .BYTE_O(bout)
  );

  always #5 clk = ~clk;

  function automatic bit bytes_match();
    if (got_bytes.size() != exp_bytes.size()) return 1'b0;
    foreach (exp_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle_inputs();
    start = 0; cfg = '0; crdy = 0; svalid = 0; stat = '0;
    dvalid = 0; din = '0; brdy = 0;
  endtask

  // Builds the buffer contents and the expected byte stream for one capture.
  task automatic prep(input int n_idle, input logic [31:0] w0, input logic [31:0] w1,
                      input bit rnd_status);
    logic [31:0] w;
    status_q.delete(); data_q.delete(); got_ctrl.delete();
    got_bytes.delete(); exp_bytes.delete();
    done_cnt = 0; ctrl_stall = 0; byte_stall_at = -1; byte_stall_len = 0;
    abort_at = -1; rnd_bp = 0; poke_start = 0;
    for (int i = 0; i < n_idle; i++)
      status_q.push_back(rnd_status ? (16'($urandom) & 16'hFFFE) : 16'h0000);
    status_q.push_back(rnd_status ? (16'($urandom) | 16'h0001) : 16'h0001);
    data_q.push_back(w0);
    data_q.push_back(w1);
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic start_capture(input logic [31:0] c);
    @(negedge clk);
    start = 1; cfg = c; crdy = 0;
    @(negedge clk);
    start = 0;
    n_cmp++;
    if (cvalid !== 1'b1 || ctrl !== c || busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency: valid=%b ctrl=%h busy=%b err=%b, required valid=1 ctrl=%h busy=1 err=0",
               cvalid, ctrl, busy, err, c);
    end
  endtask

  // Plays the trace buffer and byte sink until the capture completes.
  task automatic run_capture(input int budget);
    bit          prev_bv, prev_bx, prev_cv, prev_cx, done_seen, finished, poked;
    logic [7:0]  prev_b;
    logic [31:0] prev_c;
    int          bstall, cstall;
    prev_bv = 0; prev_bx = 0; prev_cv = 0; prev_cx = 0; prev_b = '0; prev_c = '0;
    done_seen = 0; finished = 0; poked = 0;
    bstall = byte_stall_len; cstall = ctrl_stall;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (done_seen) begin
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        finished = 1;
        break;
      end
      if (prev_bv && !prev_bx) begin
        n_cmp++;
        if (bvalid !== 1'b1 || bout !== prev_b) begin
          n_fail++;
          $display("FAIL byte_hold: valid=%b byte=%h, required 1 %h", bvalid, bout, prev_b);
        end
      end
      if (prev_cv && !prev_cx) begin
        n_cmp++;
        if (cvalid !== 1'b1 || ctrl !== prev_c) begin
          n_fail++;
          $display("FAIL ctrl_hold: valid=%b ctrl=%h, required 1 %h", cvalid, ctrl, prev_c);
        end
      end
      if (cvalid === 1'b1) begin
        n_cmp++;
        if (srdy !== 1'b0) begin
          n_fail++;
          $display("FAIL status_ready_during_ctrl: got %b, required 0", srdy);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_seen = 1;
      end
      if (abort_at >= 0 && got_bytes.size() >= abort_at) return;

      start = 0;
      if (poke_start && !poked && bvalid === 1'b1) begin
        start = 1; cfg = 32'hFFFF_FFFF; poked = 1;
      end
      if (cvalid === 1'b1 && cstall > 0) begin
        crdy = 0; cstall--;
      end else crdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      svalid = (status_q.size() > 0) && (!rnd_bp || $urandom_range(0, 2) != 0);
      stat   = svalid ? status_q[0] : 16'($urandom);
      if (svalid && srdy === 1'b1) void'(status_q.pop_front());
      dvalid = (data_q.size() > 0) && (!rnd_bp || $urandom_range(0, 2) != 0);
      din    = dvalid ? data_q[0] : $urandom;
      if (dvalid && drdy === 1'b1) void'(data_q.pop_front());
      if (bvalid === 1'b1 && bstall > 0 && got_bytes.size() == byte_stall_at) begin
        brdy = 0; bstall--;
      end else brdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;

      if (bvalid === 1'b1) begin
        n_cmp++;
        if (got_bytes.size() >= exp_bytes.size() || bout !== exp_bytes[got_bytes.size()]) begin
          n_fail++;
          $display("FAIL byte_value: index=%0d got %h, required %h", got_bytes.size(), bout,
                   (got_bytes.size() < exp_bytes.size()) ? exp_bytes[got_bytes.size()] : 8'h00);
        end
      end
      if (bvalid === 1'b1 && brdy) got_bytes.push_back(bout);
      if (cvalid === 1'b1 && crdy) got_ctrl.push_back(ctrl);
      prev_bv = bvalid; prev_bx = bvalid && brdy; prev_b = bout;
      prev_cv = cvalid; prev_cx = cvalid && crdy; prev_c = ctrl;
    end
    if (!finished) begin
      n_cmp++; n_fail++;
      $display("FAIL capture_budget: no completion within %0d cycles, bytes=%0d", budget,
               got_bytes.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, cvalid, ctrl, srdy, drdy, bvalid, bout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b cv=%b ctrl=%h sr=%b dr=%b bv=%b byte=%h, required all 0",
               busy, done, err, cvalid, ctrl, srdy, drdy, bvalid, bout);
    end
    rst_n = 1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, cvalid, srdy, drdy, bvalid} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b cv=%b, required 0", busy, done, cvalid);
    end
  endtask

  task automatic test_basic();
    prep(2, 32'hAABB_CCDD, 32'h1122_3344, 0);
    start_capture(32'h0000_0105);
    run_capture(200);
    n_cmp++;
    if (got_ctrl.size() != 1 || got_ctrl[0] !== 32'h0000_0105) begin
      n_fail++;
      $display("FAIL basic_ctrl: transfers=%0d first=%h, required 1 00000105", got_ctrl.size(),
               (got_ctrl.size() > 0) ? got_ctrl[0] : 32'h0);
    end
    n_cmp++;
    if (!bytes_match()) begin
      n_fail++;
      $display("FAIL basic_bytes: got %0d bytes, required 8 matching DD CC BB AA 44 33 22 11",
               got_bytes.size());
    end
    n_cmp++;
    if (done_cnt != 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: pulses=%0d err=%b, required 1 0", done_cnt, err);
    end
  endtask

  task automatic test_byte_backpressure();
    prep(1, 32'hAABB_CCDD, 32'h1122_3344, 0);
    byte_stall_at = 2; byte_stall_len = 5;
    start_capture(32'h0000_0105);
    run_capture(200);
    n_cmp++;
    if (!bytes_match() || done_cnt != 1) begin
      n_fail++;
      $display("FAIL byte_bp_stream: bytes=%0d done=%0d, required 8 exact bytes and 1 done",
               got_bytes.size(), done_cnt);
    end
  endtask

  task automatic test_ctrl_backpressure();
    prep(0, 32'h0102_0304, 32'hF0E0_D0C0, 0);
    ctrl_stall = 10;
    start_capture(32'h5A5A_0001);
    run_capture(200);
    n_cmp++;
    if (got_ctrl.size() != 1 || got_ctrl[0] !== 32'h5A5A_0001 || !bytes_match()) begin
      n_fail++;
      $display("FAIL ctrl_bp: transfers=%0d bytes=%0d, required 1 transfer of 5a5a0001 and 8 bytes",
               got_ctrl.size(), got_bytes.size());
    end
  endtask

  task automatic test_start_busy();
    prep(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    poke_start = 1;
    start_capture(32'h0000_0105);
    run_capture(200);
    n_cmp++;
    if (got_ctrl.size() != 1 || got_ctrl[0] !== 32'h0000_0105 || done_cnt != 1 || !bytes_match()) begin
      n_fail++;
      $display("FAIL start_while_busy: transfers=%0d done=%0d bytes=%0d, required 1 done 1 bytes 8",
               got_ctrl.size(), done_cnt, got_bytes.size());
    end
    prep(0, 32'h0BAD_F00D, 32'h1234_5678, 0);
    start_capture(32'hFFFF_FFFF);
    run_capture(200);
    n_cmp++;
    if (got_ctrl.size() != 1 || got_ctrl[0] !== 32'hFFFF_FFFF || !bytes_match()) begin
      n_fail++;
      $display("FAIL start_from_idle: ctrl=%h bytes=%0d, required ffffffff 8",
               (got_ctrl.size() > 0) ? got_ctrl[0] : 32'h0, got_bytes.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] c;
    for (int it = 0; it < 6; it++) begin
      prep($urandom_range(0, 4), $urandom, $urandom, 1);
      rnd_bp = 1;
      c = $urandom;
      start_capture(c);
      run_capture(2000);
      n_cmp++;
      if (got_ctrl.size() != 1 || got_ctrl[0] !== c || !bytes_match() || done_cnt != 1 ||
          status_q.size() != 0 || data_q.size() != 0) begin
        n_fail++;
        $display("FAIL random_capture[%0d]: ctrl_n=%0d bytes=%0d done=%0d left_s=%0d left_d=%0d",
                 it, got_ctrl.size(), got_bytes.size(), done_cnt, status_q.size(), data_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int late_done;
    prep(1, 32'h8899_AABB, 32'hCCDD_EEFF, 0);
    abort_at = 5;
    start_capture(32'h0000_0042);
    run_capture(200);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, err, cvalid, ctrl, srdy, drdy, bvalid, bout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_drain_outputs: busy=%b done=%b bv=%b byte=%h ctrl=%h, required all 0",
               busy, done, bvalid, bout, ctrl);
    end
    idle_inputs();
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) late_done++;
    end
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) late_done++;
    end
    n_cmp++;
    if (late_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d cycles with done/busy, required 0", late_done);
    end
    prep(3, 32'h1357_9BDF, 32'h2468_ACE0, 1);
    start_capture(32'h0000_0077);
    run_capture(200);
    n_cmp++;
    if (got_ctrl.size() != 1 || got_ctrl[0] !== 32'h0000_0077 || !bytes_match() || done_cnt != 1) begin
      n_fail++;
      $display("FAIL capture_after_reset: ctrl_n=%0d bytes=%0d done=%0d, required 1 8 1",
               got_ctrl.size(), got_bytes.size(), done_cnt);
    end
  endtask

`ifdef STB_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int  wait_cycles;
    bit  seen;
    prep(0, 32'h0, 32'h0, 0);
    start_capture(32'h0000_0999);
    wait_cycles = 0; seen = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (srdy === 1'b1) wait_cycles++;
      crdy = 1; svalid = 1; stat = 16'($urandom) & 16'hFFFE;
    end
    idle_inputs();
    n_cmp++;
    if (!seen || wait_cycles != 100 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: done_seen=%b wait=%0d err=%b, required 1 100 1", seen, wait_cycles, err);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b busy=%b, required 1 0", err, busy);
    end
    prep(1, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 0);
    start_capture(32'h0000_0105);
    run_capture(200);
    n_cmp++;
    if (!bytes_match() || err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_timeout: bytes=%0d err=%b, required 8 0", got_bytes.size(), err);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_basic();
    test_byte_backpressure();
    test_ctrl_backpressure();
    test_start_busy();
    test_random();
    test_reset_mid_drain();
`ifdef STB_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
